// File: rtl/fpadder_host.sv
// fpadder_host: valid/ready initiator that serialises an operand pair onto a serial fpadder and returns its sum.
// Define FPH_TIMEOUT_EN to add a WAIT-state watchdog that answers qNaN with rsp_err set.
module fpadder_host #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_sum,
    output logic             rsp_err,
    output logic [31:0]      add_a,
    input  logic             add_ready,
    input  logic [31:0]      add_sum,
    output logic [CNT_W-1:0] ops_count
);
    typedef enum logic [2:0] {INIT, IDLE, SEND_A, SEND_B, WAIT, RESP} state_t;
    state_t      state;
    logic        add_ready_q;
    logic [31:0] b_q;
    logic        rise;
    // Only a fresh low-to-high edge marks completion; a ready level carried into WAIT does not.
    assign rise = add_ready & ~add_ready_q;
`ifdef FPH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt;
    logic          expire;
    assign expire = (wcnt == TW'(TIMEOUT_CYCLES - 1));
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= INIT;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_sum     <= '0;
            rsp_err     <= 1'b0;
            add_a       <= '0;
            ops_count   <= '0;
            add_ready_q <= 1'b0;
            b_q         <= '0;
`ifdef FPH_TIMEOUT_EN
            wcnt        <= '0;
`endif
        end else begin
            add_ready_q <= add_ready;
            case (state)
                INIT: if (add_ready) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                IDLE: if (req_valid) begin
                    add_a     <= req_a;
                    b_q       <= req_b;
                    req_ready <= 1'b0;
                    state     <= SEND_A;
                end
                SEND_A: begin
                    add_a <= b_q;
                    state <= SEND_B;
                end
                SEND_B: begin
                    add_a <= '0;
                    state <= WAIT;
`ifdef FPH_TIMEOUT_EN
                    wcnt  <= '0;
`endif
                end
                WAIT: if (rise) begin
                    rsp_sum   <= add_sum;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`ifdef FPH_TIMEOUT_EN
                else if (expire) begin
                    rsp_sum   <= 32'h7FC0_0000;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
`endif
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    ops_count <= ops_count + 1'b1;
                    // After a watchdog answer the adder state is unknown, so resynchronise on its ready.
                    state     <= rsp_err ? INIT : IDLE;
                    req_ready <= ~rsp_err;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadder_host.sv
// tb_fpadder_host: randomized scoreboard bench with an exact half-unit float reference and a behavioural serial adder.
module tb_fpadder_host;
    localparam int CW = 4;
    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_sum;
    logic          rsp_err;
    logic [31:0]   add_a;
    logic          add_ready;
    logic [31:0]   add_sum;
    logic [CW-1:0] ops_count;

    typedef struct {logic [31:0] sum; logic err;} exp_t;
    exp_t        exp_q[$];
    logic [63:0] op_q[$];
    int tests = 0;
    int errs = 0;
    int cyc = 0;
    int rose_cyc = 0;
    int stall_cfg = -1;
    int force_lat = -1;
    bit hang = 0;

    fpadder_host #(.TIMEOUT_CYCLES(8), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_err(rsp_err), .add_a(add_a), .add_ready(add_ready),
        .add_sum(add_sum), .ops_count(ops_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Values are integers in units of 0.5, so every sum below 2^23 units is exact in single precision.
    function automatic logic [31:0] i2f(int v);
        int m;
        int msb;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = v < 0 ? -v : v;
        msb = 0;
        for (int i = 0; i < 31; i++) if (m[i]) msb = i;
        r[31] = v < 0;
        r[30:23] = 8'(126 + msb);
        r[22:0] = 23'(m << (23 - msb));
        return r;
    endfunction

    function automatic int f2i(logic [31:0] f);
        int v;
        if (f[30:0] == 31'h0) return 0;
        v = int'({8'd0, 1'b1, f[22:0]}) >> (149 - int'(f[30:23]));
        return f[31] ? -v : v;
    endfunction

    // Behavioural serial adder: takes A then B on consecutive cycles, drops ready, answers after a latency.
    initial begin
        logic [63:0] op;
        logic [31:0] ca, cb;
        bit keep;
        int lat;
        add_ready = 1'b0;
        add_sum = 32'h0;
        repeat (3) @(negedge clock);
        #1 add_ready = 1'b1;
        forever begin
            @(negedge clock); #1;
            if (!reset) check("add_a_idle", add_a, 32'h0);
            if (!reset && req_valid && req_ready) begin
                op = op_q.size() > 0 ? op_q.pop_front() : 64'h0;
                @(negedge clock); #1; ca = add_a;
                @(negedge clock); #1; cb = add_a;
                keep = !hang && force_lat <= 0 && ($urandom_range(0, 1) == 1);
                if (!keep) add_ready = 1'b0;
                check("add_a_opA", ca, op[63:32]);
                check("add_a_opB", cb, op[31:0]);
                lat = force_lat > 0 ? force_lat : int'($urandom_range(1, 6));
                if (hang) while (hang) begin @(negedge clock); #1; end
                else repeat (lat) begin @(negedge clock); #1; end
                if (keep) begin add_ready = 1'b0; @(negedge clock); #1; end
                add_sum = i2f(f2i(ca) + f2i(cb));
                add_ready = 1'b1;
                rose_cyc = cyc;
            end
        end
    end

    // Response monitor and scoreboard; also owns rsp_ready backpressure and the ops_count model.
    initial begin
        exp_t e;
        bit holding;
        bit cnt_chk;
        int wait_n;
        int model_cnt;
        logic [31:0] held;
        holding = 0; cnt_chk = 0; wait_n = 0; model_cnt = 0; held = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clock); #2;
            if (reset) begin
                exp_q.delete();
                holding = 0; cnt_chk = 0; model_cnt = 0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                if (!holding) begin
                    if (exp_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                    else begin
                        e = exp_q.pop_front();
                        check("rsp_sum", rsp_sum, e.sum);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (!e.err) check("rsp_latency", 32'(cyc), 32'(rose_cyc + 1));
                    end
                    held = rsp_sum;
                    holding = 1;
                    wait_n = stall_cfg < 0 ? int'($urandom_range(0, 2)) : stall_cfg;
                end else begin
                    check("rsp_stable", rsp_sum, held);
                    check("req_ready_busy", 32'(req_ready), 32'h0);
                end
                rsp_ready = (wait_n == 0);
                if (wait_n > 0) wait_n--;
                if (rsp_ready) begin holding = 0; model_cnt++; cnt_chk = 1; end
            end else begin
                if (holding) check("rsp_valid_held", 32'(rsp_valid), 32'h1);
                holding = 0;
                rsp_ready = 1'b0;
                if (cnt_chk) check("ops_count", 32'(ops_count), 32'(model_cnt % (1 << CW)));
                cnt_chk = 0;
            end
        end
    end

    task automatic issue(logic [31:0] a, logic [31:0] b, logic [31:0] sum, logic err);
        int n;
        req_a = a; req_b = b; req_valid = 1'b1;
        exp_q.push_back('{sum: sum, err: err});
        op_q.push_back({a, b});
        n = 0;
        while (!req_ready && n < 300) begin @(negedge clock); n++; end
        if (!req_ready) check("req_accept", 32'(req_ready), 32'h1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic issue_rand();
        int ia, ib;
        ia = int'($urandom_range(0, 8000)) - 4000;
        ib = int'($urandom_range(0, 8000)) - 4000;
        issue(i2f(ia), i2f(ib), i2f(ia + ib), 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin @(negedge clock); n++; end
        while (!(exp_q.size() == 0 && !rsp_valid) && n < 400);
        if (n >= 400) check("wait_done", 32'(rsp_valid), 32'h0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clock); n++; end
        check("req_ready_back", 32'(req_ready), 32'h1);
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_sum", rsp_sum, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_add_a", add_a, 32'h0);
        check("rst_ops_count", 32'(ops_count), 32'h0);
        // Request pending before the adder reports ready: nothing may leave the block.
        reset = 1'b0;
        req_a = 32'h3F80_0000; req_b = 32'h3F80_0000; req_valid = 1'b1;
        n = 0;
        while (!add_ready && n < 20) begin
            check("init_req_ready", 32'(req_ready), 32'h0);
            check("init_add_a", add_a, 32'h0);
            @(negedge clock); n++;
        end
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        wait_done();
        check("ops_after_1", 32'(ops_count), 32'h1);
        stall_cfg = 3;
        issue(32'h4020_0000, 32'hBF80_0000, 32'h3FC0_0000, 1'b0);
        wait_done();
        stall_cfg = -1;
        check("ops_after_2", 32'(ops_count), 32'h2);
        // Reset during WAIT; the adder's late rise must not produce a response.
        force_lat = 30;
        issue(i2f(6), i2f(2), i2f(8), 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_rsp_sum", rsp_sum, 32'h0);
        check("midrst_rsp_err", 32'(rsp_err), 32'h0);
        check("midrst_add_a", add_a, 32'h0);
        check("midrst_ops_count", 32'(ops_count), 32'h0);
        reset = 1'b0;
        n = 0;
        while (!add_ready && n < 60) begin
            check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
            @(negedge clock); n++;
        end
        repeat (3) @(negedge clock);
        check("midrst_no_rsp_late", 32'(rsp_valid), 32'h0);
        check("midrst_idle", 32'(req_ready), 32'h1);
        force_lat = -1;
        // Back-to-back random operations; 20 responses wrap the 4-bit counter.
        for (int i = 0; i < 20; i++) issue_rand();
        wait_done();
        check("ops_wrap", 32'(ops_count), 32'(20 % (1 << CW)));
`ifdef FPH_TIMEOUT_EN
        hang = 1;
        issue(i2f(2), i2f(4), 32'h7FC0_0000, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 9) check("tmo_early", 32'(rsp_valid), 32'h0);
            if (i == 10) check("tmo_fire", 32'(rsp_valid), 32'h1);
        end
        wait_done();
        repeat (5) begin @(negedge clock); check("tmo_init", 32'(req_ready), 32'h0); end
        hang = 0;
        wait_ready();
        issue_rand();
        wait_done();
        check("ops_after_tmo", 32'(ops_count), 32'(22 % (1 << CW)));
`endif
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "bench time limit reached");
    end
endmodule
